// File: rtl/arb_mux_4_rr_pkg.sv
// Shared types and helpers for the 4-way round-robin packet-locking arbiter.
// Holds the FSM state encoding and the rotating-priority winner search.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_mux_4_rr_if.sv
// Valid/ready bundle between four requesters, the arbiter and the single consumer.
// slave = arbiter side, master = environment side (requesters plus consumer).
interface arb_mux_4_rr_if #(
  parameter int N = 64
);

  logic [3:0]   i_vld;
  logic [3:0]   i_last;
  logic [N-1:0] i_in0;
  logic [N-1:0] i_in1;
  logic [N-1:0] i_in2;
  logic [N-1:0] i_in3;
  logic [3:0]   o_rdy;
  logic         o_vld;
  logic         o_last;
  logic [N-1:0] o_data;
  logic         i_rdy;
  logic [1:0]   o_grant;
  logic         o_busy;

  modport slave (
    input  i_vld, i_last, i_in0, i_in1, i_in2, i_in3, i_rdy,
    output o_rdy, o_vld, o_last, o_data, o_grant, o_busy
  );

  modport master (
    output i_vld, i_last, i_in0, i_in1, i_in2, i_in3, i_rdy,
    input  o_rdy, o_vld, o_last, o_data, o_grant, o_busy
  );

endinterface

// File: rtl/arb_mux_4_rr_mux_4.sv
// Plain 4:1 data mux steered by the arbiter grant.
module mux_4 #(
  parameter int N = 64
) (
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic [N-1:0] i_d2,
  input  logic [N-1:0] i_d3,
  input  logic [1:0]   i_s,
  output logic [N-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_s)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

// File: rtl/arb_mux_4_rr.sv
// Round-robin arbiter that locks one requester for a whole packet and forwards
// its beats to a single consumer; ready is routed back to the granted requester only.
module arb_mux_4_rr
  import arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  arb_mux_4_rr_if.slave bus
);

  arb_state_t r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_grant;

  logic       w_busy;
  logic       w_gvld;
  logic       w_glast;
  logic       w_xfer;
  logic [1:0] w_pick;
  logic [3:0] w_rdy;
  logic [N-1:0] w_data;

  assign w_busy  = (r_state == ARB_BUSY);
  assign w_gvld  = bus.i_vld[r_grant];
  assign w_glast = bus.i_last[r_grant];
  assign w_xfer  = w_busy & w_gvld & bus.i_rdy;
  assign w_pick  = rr_pick(bus.i_vld, r_ptr);
  assign w_rdy   = 4'(bus.i_rdy) << r_grant;

  mux_4 #(.N(N)) u_mux (
    .i_d0 (bus.i_in0),
    .i_d1 (bus.i_in1),
    .i_d2 (bus.i_in2),
    .i_d3 (bus.i_in3),
    .i_s  (r_grant),
    .o_y  (w_data)
  );

  // Output handshake is combinational off the lock so a stalled beat needs no skid storage.
  assign bus.o_vld   = w_busy & w_gvld;
  assign bus.o_last  = w_busy & w_glast;
  assign bus.o_rdy   = w_busy ? w_rdy : 4'b0000;
  assign bus.o_data  = w_data;
  assign bus.o_grant = r_grant;
  assign bus.o_busy  = w_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= 2'd3;
      r_grant <= 2'd0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|bus.i_vld) begin
            r_grant <= w_pick;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Lock releases only on an accepted last beat; a dropped valid just pauses the packet.
          if (w_xfer && w_glast) begin
            r_ptr   <= r_grant;
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_mux_4_rr.sv
// Directed bench for arb_mux_4_rr: expected beats are queued when driven and
// checked as each accepted beat appears on the output.
module tb_arb_mux_4_rr;

  localparam int N = 64;

  typedef struct {
    logic [1:0]   g;
    logic [N-1:0] d;
    logic         l;
  } exp_t;

  logic i_clk;
  logic i_rst_n;
  exp_t q[$];
  int   n_assert;
  int   n_fail;
  int   ncyc;

  arb_mux_4_rr_if #(.N(N)) bus ();

  arb_mux_4_rr #(.N(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [N-1:0] d, input logic l);
    exp_t e;
    e.g = g;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  // Sample on the falling edge, then advance past the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge i_clk);
    if (bus.o_vld && bus.i_rdy) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("beat_grant", N'(bus.o_grant), N'(e.g));
        chk("beat_data", bus.o_data, e.d);
        chk("beat_last", N'(bus.o_last), N'(e.l));
        chk("beat_rdy", N'(bus.o_rdy), N'(4'b0001 << e.g));
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_until_empty(input int max, output int n);
    n = 0;
    while (q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", N'(q.size()), 0);
  endtask

  task automatic clear_inputs();
    bus.i_vld  = 4'b0000;
    bus.i_last = 4'b0000;
    bus.i_in0  = '0;
    bus.i_in1  = '0;
    bus.i_in2  = '0;
    bus.i_in3  = '0;
    bus.i_rdy  = 1'b1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    clear_inputs();
    q.delete();
    cycle();
    cycle();
    i_rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    clear_inputs();

    // Reset state
    do_reset();
    chk("rst_busy", N'(bus.o_busy), 0);
    chk("rst_grant", N'(bus.o_grant), 0);
    chk("rst_vld", N'(bus.o_vld), 0);
    chk("rst_rdy", N'(bus.o_rdy), 0);

    // 1) single beat from req0, one cycle latency
    bus.i_vld  = 4'b0001;
    bus.i_last = 4'b0001;
    bus.i_in0  = 64'hA5;
    push(2'd0, 64'hA5, 1'b1);
    chk("t1_idle_vld", N'(bus.o_vld), 0);
    chk("t1_idle_rdy", N'(bus.o_rdy), 0);
    cycle();
    chk("t1_busy", N'(bus.o_busy), 1);
    chk("t1_grant", N'(bus.o_grant), 0);
    chk("t1_vld", N'(bus.o_vld), 1);
    chk("t1_data", bus.o_data, 64'hA5);
    cycle();
    chk("t1_sb_empty", N'(q.size()), 0);
    chk("t1_idle_after", N'(bus.o_busy), 0);
    chk("t1_vld_bubble", N'(bus.o_vld), 0);
    bus.i_vld = 4'b0000;

    // 2) all requesting, single-beat packets: order 0,1,2,3,0 with bubbles
    do_reset();
    bus.i_vld  = 4'b1111;
    bus.i_last = 4'b1111;
    bus.i_in0  = 64'h100;
    bus.i_in1  = 64'h101;
    bus.i_in2  = 64'h102;
    bus.i_in3  = 64'h103;
    push(2'd0, 64'h100, 1'b1);
    push(2'd1, 64'h101, 1'b1);
    push(2'd2, 64'h102, 1'b1);
    push(2'd3, 64'h103, 1'b1);
    push(2'd0, 64'h100, 1'b1);
    run_until_empty(20, ncyc);
    chk("t2_cycles", N'(ncyc), 10);
    clear_inputs();

    // 3) req1 3-beat packet, req2 waiting (ptr is 0 here)
    bus.i_vld  = 4'b0110;
    bus.i_last = 4'b0100;
    bus.i_in1  = 64'h11;
    bus.i_in2  = 64'h22;
    push(2'd1, 64'h11, 1'b0);
    cycle();
    chk("t3_grant", N'(bus.o_grant), 1);
    chk("t3_rdy2_b1", N'(bus.o_rdy[2]), 0);
    cycle();
    bus.i_in1 = 64'h12;
    push(2'd1, 64'h12, 1'b0);
    chk("t3_rdy2_b2", N'(bus.o_rdy[2]), 0);
    cycle();
    bus.i_in1  = 64'h13;
    bus.i_last = 4'b0110;
    push(2'd1, 64'h13, 1'b1);
    chk("t3_rdy2_b3", N'(bus.o_rdy[2]), 0);
    cycle();
    chk("t3_sb_req1_done", N'(q.size()), 0);
    bus.i_vld = 4'b0100;
    push(2'd2, 64'h22, 1'b1);
    run_until_empty(6, ncyc);
    chk("t3_req2_cycles", N'(ncyc), 2);
    clear_inputs();

    // 4) backpressure on req3 (ptr is 2 here)
    bus.i_vld = 4'b1000;
    bus.i_in3 = 64'h31;
    push(2'd3, 64'h31, 1'b0);
    cycle();
    cycle();
    bus.i_in3  = 64'h32;
    bus.i_last = 4'b1000;
    bus.i_rdy  = 1'b0;
    push(2'd3, 64'h32, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_vld", N'(bus.o_vld), 1);
      chk("t4_data", bus.o_data, 64'h32);
      chk("t4_grant", N'(bus.o_grant), 3);
      chk("t4_rdy", N'(bus.o_rdy), 0);
      chk("t4_pending", N'(q.size()), 1);
    end
    bus.i_rdy = 1'b1;
    run_until_empty(4, ncyc);
    chk("t4_release_cycles", N'(ncyc), 1);
    chk("t4_idle", N'(bus.o_busy), 0);
    clear_inputs();

    // 5) req0 drops valid mid-packet while req3 waits (ptr is 3 here)
    bus.i_vld  = 4'b1001;
    bus.i_last = 4'b1000;
    bus.i_in0  = 64'h51;
    bus.i_in3  = 64'h3F;
    push(2'd0, 64'h51, 1'b0);
    cycle();
    cycle();
    bus.i_vld = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t5_grant_hold", N'(bus.o_grant), 0);
      chk("t5_vld_low", N'(bus.o_vld), 0);
      chk("t5_busy", N'(bus.o_busy), 1);
      chk("t5_rdy3", N'(bus.o_rdy[3]), 0);
    end
    bus.i_vld  = 4'b1001;
    bus.i_last = 4'b1001;
    bus.i_in0  = 64'h52;
    push(2'd0, 64'h52, 1'b1);
    push(2'd3, 64'h3F, 1'b1);
    run_until_empty(8, ncyc);
    chk("t5_cycles", N'(ncyc), 3);
    clear_inputs();

    // 6) async reset mid-packet
    bus.i_vld = 4'b0010;
    bus.i_in1 = 64'h61;
    cycle();
    chk("t6_pre_vld", N'(bus.o_vld), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", N'(bus.o_vld), 0);
    chk("t6_rst_rdy", N'(bus.o_rdy), 0);
    chk("t6_rst_busy", N'(bus.o_busy), 0);
    chk("t6_rst_grant", N'(bus.o_grant), 0);
    q.delete();
    cycle();
    i_rst_n    = 1'b1;
    bus.i_vld  = 4'b1111;
    bus.i_last = 4'b1111;
    bus.i_in0  = 64'h70;
    push(2'd0, 64'h70, 1'b1);
    run_until_empty(4, ncyc);
    chk("t6_cycles", N'(ncyc), 2);
    clear_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
